i2s_rx_deser: RTL and testbench



---
 rtl/i2s_rx_pkg.sv | 17 +
 rtl/i2s_rx_framer.sv | 96 +++++++++
 rtl/i2s_rx_deser.sv | 99 +++++++++
 tb/tb_i2s_rx_deser.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared constants, state encoding and counter sizing for the I2S/TDM receive deserializer.
package i2s_rx_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } rx_state_e;

  function automatic int CNT_W(input int num_ch, input int slot_w);
    return (num_ch * slot_w > 1) ? $clog2(num_ch * slot_w) : 1;
  endfunction

endpackage

// File: rtl/i2s_rx_framer.sv
// Frame-sync detection, frame bit counter, state machine and framing-error detection.
// state | meaning
// IDLE  | block disabled, counters cleared
// SYNC  | enabled, waiting for a WS falling edge to mark the frame start
// RUN   | locked to frames, every sck_rise is a data bit at index bit_cnt
module i2s_rx_framer
  import i2s_rx_pkg::*;
#(
  parameter int SLOT_W = 16,
  parameter int NUM_CH = 2,
  parameter int MODE   = MODE_I2S,
  localparam int CW      = CNT_W(NUM_CH, SLOT_W),
  localparam int SLOT_BW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int POS_BW  = (SLOT_W > 1) ? $clog2(SLOT_W) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sck_rise,
  input  logic               in_ws,
  input  logic               en,
  output logic               sample_en,
  output logic [SLOT_BW-1:0] slot,
  output logic [POS_BW-1:0]  pos,
  output logic               frame_done,
  output logic               frame_err,
  output logic               active
);

  localparam logic [CW-1:0] LAST     = CW'(NUM_CH * SLOT_W - 1);
  localparam logic [CW-1:0] SLOT_LEN = CW'(SLOT_W);
  localparam bit            LJ       = (MODE == MODE_LJ);
  // I2S: the next frame's WS edge lands on the last bit; LJ: on bit 0 itself.
  localparam logic [CW-1:0] FS_POS   = LJ ? '0 : LAST;
  localparam logic [CW-1:0] START    = LJ ? CW'(1) : '0;

  rx_state_e     state;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] idx;
  logic          ws_d;
  logic          fs_edge;
  logic          run_rise;

  assign fs_edge    = sck_rise & ws_d & ~in_ws;
  assign run_rise   = en & sck_rise & (state == RUN);
  assign frame_err  = run_rise & (fs_edge != (bit_cnt == FS_POS));
  assign frame_done = run_rise & ~frame_err & (bit_cnt == LAST);

  // In LJ a frame-start edge carries bit 0 of the new frame, whatever bit_cnt says.
  assign idx       = (LJ && fs_edge) ? '0 : bit_cnt;
  assign sample_en = (run_rise & ~frame_err) | (LJ && en && fs_edge && (state != IDLE));
  assign slot      = SLOT_BW'(idx / SLOT_LEN);
  assign pos       = POS_BW'(idx % SLOT_LEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      ws_d    <= 1'b0;
      active  <= 1'b0;
    end else begin
      if (sck_rise) ws_d <= in_ws;
      if (!en) begin
        state   <= IDLE;
        bit_cnt <= '0;
        active  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: if (fs_edge) begin
            state   <= RUN;
            active  <= 1'b1;
            bit_cnt <= START;
          end
          RUN: if (sck_rise) begin
            if (frame_err && fs_edge) begin
              bit_cnt <= START;
            end else if (frame_err) begin
              state   <= SYNC;
              active  <= 1'b0;
              bit_cnt <= '0;
            end else if (bit_cnt == LAST) begin
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S / left-justified / TDM receive deserializer: per-slot shift registers and atomic frame output.
// Optional saturating error counter port out_err_cnt enabled by I2S_RX_ERR_CNT_EN.
module i2s_rx_deser
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SLOT_W = 16,
  parameter int NUM_CH = 2,
  parameter int MODE   = MODE_I2S
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sck_rise,
  input  logic                     in_ws,
  input  logic                     in_sd,
  input  logic                     en,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic                     out_err,
  output logic                     out_active
`ifdef I2S_RX_ERR_CNT_EN
  ,
  output logic [7:0]               out_err_cnt
`endif
);

  localparam int SLOT_BW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int POS_BW  = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

  logic                     sample_en;
  logic                     frame_done;
  logic                     frame_err;
  logic [SLOT_BW-1:0]       slot;
  logic [POS_BW-1:0]        pos;
  logic [DATA_W-1:0]        work     [NUM_CH];
  logic [DATA_W-1:0]        work_nxt [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] frame_pack;

  i2s_rx_framer #(
    .SLOT_W(SLOT_W),
    .NUM_CH(NUM_CH),
    .MODE  (MODE)
  ) u_framer (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck_rise  (sck_rise),
    .in_ws     (in_ws),
    .en        (en),
    .sample_en (sample_en),
    .slot      (slot),
    .pos       (pos),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .active    (out_active)
  );

  // Bits past DATA_W in a slot are dropped; the last sampled bit is folded in before staging.
  always_comb begin
    frame_pack = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      work_nxt[c] = work[c];
      if (sample_en && (int'(pos) < DATA_W) && (int'(slot) == c))
        work_nxt[c] = DATA_W'({work[c], in_sd});
      frame_pack[c*DATA_W +: DATA_W] = work_nxt[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) work[c] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) work[c] <= work_nxt[c];
      out_valid <= frame_done;
      out_err   <= frame_err;
      if (frame_done) out_data <= frame_pack;
    end
  end

`ifdef I2S_RX_ERR_CNT_EN
  logic en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d        <= 1'b0;
      out_err_cnt <= '0;
    end else begin
      en_d <= en;
      if (en && !en_d)
        out_err_cnt <= '0;
      else if (out_err && (out_err_cnt != 8'hFF))
        out_err_cnt <= out_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed scoreboard bench: a stereo I2S instance and a 4-channel LJ TDM instance.
module tb_i2s_rx_deser;
  import i2s_rx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_rise = 1'b0, s_ws = 1'b0, s_sd = 1'b0, s_en = 1'b0;
  logic [31:0] s_data;
  logic        s_valid, s_err, s_active;
  logic        t_rise = 1'b0, t_ws = 1'b0, t_sd = 1'b0, t_en = 1'b0;
  logic [95:0] t_data;
  logic        t_valid, t_err, t_active;
`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0]  s_cnt, t_cnt;
`endif

  i2s_rx_deser #(.DATA_W(16), .SLOT_W(16), .NUM_CH(2), .MODE(MODE_I2S)) dut_st (
    .clk(clk), .rst_n(rst_n), .sck_rise(s_rise), .in_ws(s_ws), .in_sd(s_sd), .en(s_en),
    .out_data(s_data), .out_valid(s_valid), .out_err(s_err), .out_active(s_active)
`ifdef I2S_RX_ERR_CNT_EN
    , .out_err_cnt(s_cnt)
`endif
  );

  i2s_rx_deser #(.DATA_W(24), .SLOT_W(32), .NUM_CH(4), .MODE(MODE_LJ)) dut_tdm (
    .clk(clk), .rst_n(rst_n), .sck_rise(t_rise), .in_ws(t_ws), .in_sd(t_sd), .en(t_en),
    .out_data(t_data), .out_valid(t_valid), .out_err(t_err), .out_active(t_active)
`ifdef I2S_RX_ERR_CNT_EN
    , .out_err_cnt(t_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail = 0;
  int s_errs = 0, t_errs = 0, both = 0;
  int s_err_exp = 0, t_err_exp = 0;
  logic [31:0] s_exp[$], s_got[$];
  logic [95:0] t_exp[$], t_got[$];
  logic [127:0] f1, f2, f3;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    if (s_valid === 1'b1) s_got.push_back(s_data);
    if (s_err === 1'b1) s_errs++;
    if (t_valid === 1'b1) t_got.push_back(t_data);
    if (t_err === 1'b1) t_errs++;
    if (s_valid === 1'b1 && s_err === 1'b1) both++;
    if (t_valid === 1'b1 && t_err === 1'b1) both++;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic sbit(input logic ws, input logic sd);
    s_ws = ws; s_sd = sd; s_rise = 1'b1;
    cyc();
    s_rise = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic tbit(input logic ws, input logic sd);
    t_ws = ws; t_sd = sd; t_rise = 1'b1;
    cyc();
    t_rise = 1'b0;
    cyc();
    cyc();
  endtask

  // I2S stereo: WS leads data by one bit, so it is high for bits 15..30 of the frame.
  task automatic st_frame(input logic [15:0] l, input logic [15:0] r, input int from, input int to);
    logic [31:0] f;
    f = {l, r};
    for (int i = from; i <= to; i++) sbit((i >= 15 && i <= 30), f[31-i]);
  endtask

  // LJ TDM: WS pulses high over the last 8 bits so its fall coincides with bit 0.
  task automatic tdm_frame(input logic [127:0] f, input int from, input int to);
    for (int i = from; i <= to; i++) tbit((i >= 120), f[127-i]);
  endtask

  function automatic logic [95:0] tdm_exp(input logic [127:0] f);
    return {f[31:8], f[63:40], f[95:72], f[127:104]};
  endfunction

  task automatic sb_st(input string tag);
    check({tag, " count"}, s_got.size(), s_exp.size());
    while (s_exp.size() > 0 && s_got.size() > 0) check(tag, s_got.pop_front(), s_exp.pop_front());
    s_exp.delete();
    s_got.delete();
  endtask

  task automatic sb_tdm(input string tag);
    check({tag, " count"}, t_got.size(), t_exp.size());
    while (t_exp.size() > 0 && t_got.size() > 0) check(tag, t_got.pop_front(), t_exp.pop_front());
    t_exp.delete();
    t_got.delete();
  endtask

  initial begin
    cycles(3);
    check("rst st data", s_data, 32'h0);
    check("rst st valid", s_valid, 1'b0);
    check("rst st err", s_err, 1'b0);
    check("rst st active", s_active, 1'b0);
    check("rst tdm data", t_data, 96'h0);
    check("rst tdm active", t_active, 1'b0);
    rst_n = 1'b1;
    cycles(2);

    // basic stereo frame
    s_en = 1'b1;
    cycles(2);
    check("st sync inactive", s_active, 1'b0);
    sbit(1'b1, 1'b0); sbit(1'b1, 1'b0); sbit(1'b0, 1'b0);
    check("st run active", s_active, 1'b1);
    st_frame(16'hA5C3, 16'h1234, 0, 31);
    s_exp.push_back(32'h1234_A5C3);
    cycles(3);
    sb_st("st frame1");
    check("st err after frame1", s_errs, s_err_exp);

    // back-to-back frames with edge values
    st_frame(16'hFFFF, 16'h0000, 0, 31);
    s_exp.push_back(32'h0000_FFFF);
    st_frame(16'h0001, 16'h8000, 0, 31);
    s_exp.push_back(32'h8000_0001);
    cycles(3);
    sb_st("st b2b");
    check("st err after b2b", s_errs, s_err_exp);

    // short frame: WS falls at bit 20, then a full frame
    st_frame(16'h0F0F, 16'hF0F0, 0, 19);
    sbit(1'b0, 1'b0);
    s_err_exp++;
    cycles(2);
    sb_st("st short dropped");
    check("st short err", s_errs, s_err_exp);
    check("st short still active", s_active, 1'b1);
    st_frame(16'h1357, 16'h2468, 0, 31);
    s_exp.push_back(32'h2468_1357);
    cycles(3);
    sb_st("st after short");

    // long frame: WS held low past the frame end
    for (int i = 0; i < 32; i++) sbit(1'b0, (i % 2 == 1));
    s_err_exp++;
    cycles(2);
    sb_st("st long dropped");
    check("st long err", s_errs, s_err_exp);
    check("st long inactive", s_active, 1'b0);
    sbit(1'b0, 1'b1); sbit(1'b0, 1'b0); sbit(1'b0, 1'b1);
    check("st sync holds", s_active, 1'b0);
    sbit(1'b1, 1'b0); sbit(1'b0, 1'b0);
    check("st relock active", s_active, 1'b1);
    st_frame(16'hC0DE, 16'h7E57, 0, 31);
    s_exp.push_back(32'h7E57_C0DE);
    cycles(3);
    sb_st("st after long");

    // enable dropped mid-frame
    st_frame(16'hDEAD, 16'hBEEF, 0, 9);
    s_en = 1'b0;
    cycles(3);
    check("st en off inactive", s_active, 1'b0);
    s_en = 1'b1;
    cycles(2);
    st_frame(16'hDEAD, 16'hBEEF, 10, 31);
    cycles(3);
    sb_st("st partial dropped");
    check("st data held", s_data, 32'h7E57_C0DE);
    check("st resume active", s_active, 1'b1);
    st_frame(16'hCAFE, 16'h0F0F, 0, 31);
    s_exp.push_back(32'h0F0F_CAFE);
    cycles(3);
    sb_st("st resume");
    check("st err total", s_errs, s_err_exp);

    // TDM 4 x 32-bit slots, 24-bit samples, left-justified
    s_en = 1'b0;
    t_en = 1'b1;
    cycles(2);
    f1 = {32'h123456AB, 32'hABCDEF12, 32'h000001FF, 32'hFFFFFF00};
    f2 = {32'h800000C3, 32'h7FFFFF3C, 32'h5A5A5A99, 32'h0F0F0F66};
    f3 = {32'h2468ACE0, 32'h13579BDF, 32'hFEDCBA01, 32'h00FF00FE};
    tbit(1'b1, 1'b0);
    tdm_frame(f1, 0, 127);
    t_exp.push_back(96'hFFFFFF_000001_ABCDEF_123456);
    tdm_frame(f2, 0, 127);
    t_exp.push_back(tdm_exp(f2));
    cycles(3);
    sb_tdm("tdm frames");
    check("tdm err none", t_errs, t_err_exp);

    // TDM short frame restarts on the early sync and captures its bit 0
    tdm_frame(f2, 0, 39);
    tbit(1'b1, 1'b1);
    tdm_frame(f3, 0, 127);
    t_err_exp++;
    t_exp.push_back(tdm_exp(f3));
    cycles(3);
    sb_tdm("tdm after short");
    check("tdm short err", t_errs, t_err_exp);

    // TDM missing sync at the next frame start
    tbit(1'b1, 1'b0);
    t_err_exp++;
    cycles(2);
    check("tdm long err", t_errs, t_err_exp);
    check("tdm long inactive", t_active, 1'b0);
    sb_tdm("tdm long dropped");
`ifdef I2S_RX_ERR_CNT_EN
    check("tdm err cnt", t_cnt, 8'd2);
`endif
    t_en = 1'b0;
    cycles(2);

`ifdef I2S_RX_ERR_CNT_EN
    s_en = 1'b1;
    cycles(2);
    check("cnt clear on en", s_cnt, 8'd0);
    sbit(1'b1, 1'b0); sbit(1'b0, 1'b0);
    repeat (100) begin sbit(1'b1, 1'b0); sbit(1'b0, 1'b0); end
    s_err_exp += 100;
    cycles(2);
    check("cnt 100", s_cnt, 8'd100);
    repeat (200) begin sbit(1'b1, 1'b0); sbit(1'b0, 1'b0); end
    s_err_exp += 200;
    cycles(2);
    check("cnt saturated", s_cnt, 8'd255);
    check("st err pulses", s_errs, s_err_exp);
    s_en = 1'b0;
    cycles(2);
    s_en = 1'b1;
    cycles(2);
    check("cnt clear after toggle", s_cnt, 8'd0);
    s_en = 1'b0;
    cycles(2);
`endif

    // reset in the middle of a frame
    s_en = 1'b1;
    cycles(2);
    sbit(1'b1, 1'b0); sbit(1'b0, 1'b0);
    st_frame(16'h5555, 16'hAAAA, 0, 7);
    rst_n = 1'b0;
    cyc();
    check("midrst data", s_data, 32'h0);
    check("midrst active", s_active, 1'b0);
    check("midrst valid", s_valid, 1'b0);
    rst_n = 1'b1;
    cycles(2);

    check("no valid with err", both, 0);
    check("st err final", s_errs, s_err_exp);
    check("tdm err final", t_errs, t_err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
